dmac_channel_ctrl: RTL
======================

Name: dmac_channel_ctrl

Overview:
- Control FSM that sequences one DMA channel datapath: address/size/burst registers, beat down-counter, 16-word FIFO and AHB master address mux.
- Loads the channel configuration on start, then alternates read bursts (source → FIFO) and write bursts (FIFO → destination).
- Finishes any remainder smaller than the burst size as single-word transfers, then signals completion.
- Sits between the DMAC configuration/arbiter logic and the channel datapath; drives the AHB master control lines for the channel.

Parameters:
- FIFO_DEPTH, 16, FIFO words; the programmed B_Size must be ≤ FIFO_DEPTH (software rule, not checked).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ch_en  in  1  start pulse; sampled only in IDLE
- hready  in  1  AHB transfer-complete
- hresp  in  1  AHB error response (1 = ERROR)
- bs0, tslb, ts0, fifo_full, fifo_empty  in  1 each  datapath status
- s_sel, d_sel, t_sel, b_sel  out  1 each  datapath mux selects (1 = load config / force single)
- s_en, d_en, ts_en, burst_en, count_en  out  1 each  datapath register enables
- h_sel  out  1  0 = source address on bus, 1 = destination
- wr_en, rd_en  out  1 each  FIFO push / pop
- trigger  out  1  gates FIFO output onto MWData
- htrans  out  2  AHB IDLE=00, NONSEQ=10, SEQ=11
- hwrite  out  1  1 during write beats
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky bus error; cleared by the next accepted ch_en

Behaviour:
- Reset: state IDLE; all outputs 0; htrans = IDLE. Reset mid-transfer aborts immediately; no done pulse.
- Outputs are Moore-decoded from state, plus the beat-complete qualifiers below. Any enable not listed for a state is 0.
- IDLE: on ch_en go to CONFIG and clear err.
- CONFIG (1 cycle): s_en, d_en, ts_en, burst_en = 1; s_sel = d_sel = t_sel = 1; b_sel = 0. Go to CHECK.
- CHECK (1 cycle):
  - If ts0, go to DONE.
  - Otherwise assert burst_en with b_sel = tslb, then go to RD_ARM.
  - A remainder smaller than B_Size therefore forces Burst_Size = 1.
- RD_ARM (1 cycle): count_en = 1. With bs0 = 1 this loads the beat counter with Burst_Size−1. Go to READ.
- READ:
  - h_sel = 0, hwrite = 0.
  - Beat issued when fifo_full = 0: htrans = NONSEQ on the first beat of the phase, SEQ on later beats. While fifo_full = 1, htrans = IDLE.
  - Beat completes when htrans ≠ IDLE and hready = 1: wr_en = 1, s_en = 1 with s_sel = 0.
    - If bs0, the phase ends and the FSM goes to WR_ARM (count_en = 0).
    - Otherwise count_en = 1.
  - hready = 0 holds htrans and address; no enables fire.
- WR_ARM (1 cycle): count_en = 1. Go to WRITE.
- WRITE:
  - h_sel = 1, hwrite = 1, trigger = 1.
  - Beat issued when fifo_empty = 0, using the same NONSEQ/SEQ rule as READ.
  - Beat completes when hready = 1: rd_en = 1, d_en = 1 with d_sel = 0.
    - If bs0, go to UPDATE.
    - Otherwise count_en = 1.
- UPDATE (1 cycle): ts_en = 1, t_sel = 0, so Transfer_Size −= Burst_Size. Go to CHECK.
- DONE (1 cycle): done = 1. Go to IDLE.
- Bus error: hresp = 1 during any READ/WRITE beat sets err and goes to ERROR. No FIFO push or pop and no counter/address update occur for that beat. ERROR (1 cycle) then returns to IDLE; done stays 0.
- ch_en while busy is ignored.
- Burst_Size = 1 (B_Size = 0 or 1, or tslb): the arm step loads 0, so bs0 stays 1 and each phase is exactly one beat.

Decomposition:
- dmac_pkg: state enum (IDLE, CONFIG, CHECK, RD_ARM, READ, WR_ARM, WRITE, UPDATE, DONE, ERROR), HTRANS_* constants, FIFO_DEPTH default.
- Single module, no sub-module. A first-beat flag register drives the NONSEQ/SEQ choice.

Test Plan:
- T_Size=8, B_Size=4, hready=1: pattern repeated twice is RD 4 beats (NONSEQ,SEQ,SEQ,SEQ) then WR 4 beats; done pulse; Src and Dst each advance by 32 bytes.
- T_Size=6, B_Size=4: one 4-beat read/write burst, then two single read/write pairs (NONSEQ only); done pulse after the 6th write.
- T_Size=0: no htrans activity; done asserted 3 cycles after the ch_en edge (CONFIG, CHECK, DONE).
- B_Size=0, T_Size=3: three single-beat read/write pairs; Burst_Size loaded as 1.
- hready low for 2 cycles mid-read: htrans/address held; exactly one wr_en per completed beat; FIFO count correct.
- hresp=1 on the 2nd write beat: err=1, no rd_en for that beat, return to IDLE with no done pulse. A following ch_en clears err.
- rst asserted mid-WRITE: all outputs 0 and state IDLE in the same cycle.

Source files
------------

// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared types and constants for the DMA channel controller
package dmac_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CONFIG,
      S_CHECK,
      S_RD_ARM,
      S_READ,
      S_WR_ARM,
      S_WRITE,
      S_UPDATE,
      S_DONE,
      S_ERROR
   } dmac_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // Programmed burst length must not exceed this; software guarantees it.
   localparam int FIFO_DEPTH = 16;

endpackage

// File: rtl/dmac_channel_ctrl.sv
// rtl/dmac_channel_ctrl.sv - control FSM sequencing one DMA channel datapath and its AHB master
module dmac_channel_ctrl
   import dmac_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_ch_en,
   input  logic       i_hready,
   input  logic       i_hresp,
   input  logic       i_bs0,
   input  logic       i_tslb,
   input  logic       i_ts0,
   input  logic       i_fifo_full,
   input  logic       i_fifo_empty,
   output logic       o_s_sel,
   output logic       o_d_sel,
   output logic       o_t_sel,
   output logic       o_b_sel,
   output logic       o_s_en,
   output logic       o_d_en,
   output logic       o_ts_en,
   output logic       o_burst_en,
   output logic       o_count_en,
   output logic       o_h_sel,
   output logic       o_wr_en,
   output logic       o_rd_en,
   output logic       o_trigger,
   output logic [1:0] o_htrans,
   output logic       o_hwrite,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err
);

   dmac_state_e r_state;
   dmac_state_e w_next;
   logic        r_first;
   logic        r_err;
   logic        w_issue;
   logic        w_bus_err;
   logic        w_beat;

   // A beat is on the bus whenever the FIFO can accept (read) or supply (write) a word.
   assign w_issue   = ((r_state == S_READ)  && !i_fifo_full) ||
                      ((r_state == S_WRITE) && !i_fifo_empty);
   assign w_bus_err = w_issue && i_hresp;
   assign w_beat    = w_issue && i_hready && !i_hresp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // First-beat flag selects NONSEQ for the opening beat of each phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_first <= 1'b1;
      end else if (r_state == S_RD_ARM || r_state == S_WR_ARM) begin
         r_first <= 1'b1;
      end else if (w_beat) begin
         r_first <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (r_state == S_IDLE && i_ch_en) begin
         r_err <= 1'b0;
      end else if (w_bus_err) begin
         r_err <= 1'b1;
      end
   end

   always_comb begin
      w_next     = r_state;
      o_s_sel    = 1'b0;
      o_d_sel    = 1'b0;
      o_t_sel    = 1'b0;
      o_b_sel    = 1'b0;
      o_s_en     = 1'b0;
      o_d_en     = 1'b0;
      o_ts_en    = 1'b0;
      o_burst_en = 1'b0;
      o_count_en = 1'b0;
      o_h_sel    = 1'b0;
      o_wr_en    = 1'b0;
      o_rd_en    = 1'b0;
      o_trigger  = 1'b0;
      o_htrans   = HTRANS_IDLE;
      o_hwrite   = 1'b0;
      o_done     = 1'b0;
      if (w_issue) begin
         o_htrans = r_first ? HTRANS_NONSEQ : HTRANS_SEQ;
      end
      case (r_state)
         S_IDLE: begin
            if (i_ch_en) w_next = S_CONFIG;
         end
         S_CONFIG: begin
            o_s_en     = 1'b1;
            o_d_en     = 1'b1;
            o_ts_en    = 1'b1;
            o_burst_en = 1'b1;
            o_s_sel    = 1'b1;
            o_d_sel    = 1'b1;
            o_t_sel    = 1'b1;
            w_next     = S_CHECK;
         end
         S_CHECK: begin
            if (i_ts0) begin
               w_next = S_DONE;
            end else begin
               o_burst_en = 1'b1;
               o_b_sel    = i_tslb;
               w_next     = S_RD_ARM;
            end
         end
         S_RD_ARM: begin
            o_count_en = 1'b1;
            w_next     = S_READ;
         end
         S_READ: begin
            if (w_bus_err) begin
               w_next = S_ERROR;
            end else if (w_beat) begin
               o_wr_en = 1'b1;
               o_s_en  = 1'b1;
               if (i_bs0) w_next = S_WR_ARM;
               else       o_count_en = 1'b1;
            end
         end
         S_WR_ARM: begin
            o_count_en = 1'b1;
            w_next     = S_WRITE;
         end
         S_WRITE: begin
            o_h_sel   = 1'b1;
            o_hwrite  = 1'b1;
            o_trigger = 1'b1;
            if (w_bus_err) begin
               w_next = S_ERROR;
            end else if (w_beat) begin
               o_rd_en = 1'b1;
               o_d_en  = 1'b1;
               if (i_bs0) w_next = S_UPDATE;
               else       o_count_en = 1'b1;
            end
         end
         S_UPDATE: begin
            o_ts_en = 1'b1;
            w_next  = S_CHECK;
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         S_ERROR: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign o_busy = (r_state != S_IDLE);
   assign o_err  = r_err;

endmodule
